// File: rtl/lcd1602_bus_arbiter_if.sv
// Requester-side handshake bundle for the LCD1602 bus arbiter.
//
// Two independent requesters each present valid/rs/data and receive a
// one-cycle ready pulse when their write is accepted.
//   master : requester side (drives valid/rs/data, sees ready)
//   slave  : arbiter side   (sees valid/rs/data, drives ready)
interface lcd1602_bus_arbiter_if;
  logic       req0_valid;
  logic       req0_rs;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic       req1_rs;
  logic [7:0] req1_data;
  logic       req1_ready;

  modport master (
    output req0_valid, req0_rs, req0_data,
    input  req0_ready,
    output req1_valid, req1_rs, req1_data,
    input  req1_ready
  );

  modport slave (
    input  req0_valid, req0_rs, req0_data,
    output req0_ready,
    input  req1_valid, req1_rs, req1_data,
    output req1_ready
  );
endinterface

// File: rtl/lcd1602_bus_arbiter.sv
// LCD1602 parallel-bus owner and two-client round-robin arbiter.
//
// After reset the block waits POWERUP_CYC cycles and then issues the fixed
// init sequence (0x38, 0x08, 0x01, 0x06, 0x0C, all rs=0) on its own. Once
// init_done is set it accepts one write at a time from two requesters with
// round-robin arbitration. Every write is SETUP_CYC cycles of en low with
// rs/data stable, then EN_CYC cycles of en high; clear (0x01) and home
// (0x02) commands get CLR_WAIT_CYC extra idle cycles afterwards.
//
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   req        : requester handshake bundle (slave modport)
//   init_done  : init sequence complete, sticky until reset
//   busy       : an init or client transaction is in progress
//   lcd_rs, lcd_rw, lcd_en, lcd_data : LCD bus (lcd_rw is always 0)
module lcd1602_bus_arbiter #(
  parameter int SETUP_CYC    = 500,
  parameter int EN_CYC       = 500,
  parameter int POWERUP_CYC  = 7500,
  parameter int CLR_WAIT_CYC = 80000,
  parameter int CNT_W        = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  lcd1602_bus_arbiter_if.slave        req,
  output logic                        init_done,
  output logic                        busy,
  output logic                        lcd_rs,
  output logic                        lcd_rw,
  output logic                        lcd_en,
  output logic [7:0]                  lcd_data
);

  localparam logic [2:0] PWRUP    = 3'd0;
  localparam logic [2:0] INIT_CMD = 3'd1;
  localparam logic [2:0] IDLE     = 3'd2;
  localparam logic [2:0] SETUP    = 3'd3;
  localparam logic [2:0] STROBE   = 3'd4;
  localparam logic [2:0] WAIT     = 3'd5;

  localparam logic [2:0] INIT_LAST_IDX = 3'd4;

  // Each timed state ends when the counter reaches its length minus one.
  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(POWERUP_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_WAIT_CYC - 1);

  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       init_idx_reg, init_idx_next;
  logic             last_reg, last_next;
  logic             init_done_reg, init_done_next;
  logic             busy_reg, busy_next;
  logic             lcd_rs_reg, lcd_rs_next;
  logic [7:0]       lcd_data_reg, lcd_data_next;
  logic             lcd_en_reg, lcd_en_next;

  logic             arb_open;
  logic             ready0;
  logic             ready1;
  logic             is_slow_cmd;
  logic             txn_done;
  logic [2:0]       ret_state;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    init_cmd = 8'h38;
      3'd1:    init_cmd = 8'h08;
      3'd2:    init_cmd = 8'h01;
      3'd3:    init_cmd = 8'h06;
      3'd4:    init_cmd = 8'h0C;
      default: init_cmd = 8'h00;
    endcase
  endfunction

  // Clients are only ever offered the bus in IDLE after init. A lone
  // requester always wins; under contention the one that did not win
  // last time goes next.
  assign arb_open = (state_reg == IDLE) && init_done_reg;
  assign ready0   = arb_open && req.req0_valid && (!req.req1_valid || last_reg);
  assign ready1   = arb_open && req.req1_valid && (!req.req0_valid || !last_reg);

  assign req.req0_ready = ready0;
  assign req.req1_ready = ready1;

  // Clear display and return home need the long busy wait.
  assign is_slow_cmd = !lcd_rs_reg && ((lcd_data_reg == 8'h01) || (lcd_data_reg == 8'h02));

  // A finished transaction returns to IDLE for clients, or steps the init
  // sequence while init is still running.
  assign ret_state = init_done_reg ? IDLE : INIT_CMD;

  always_comb begin
    state_next     = state_reg;
    init_idx_next  = init_idx_reg;
    last_next      = last_reg;
    init_done_next = init_done_reg;
    busy_next      = busy_reg;
    lcd_rs_next    = lcd_rs_reg;
    lcd_data_next  = lcd_data_reg;
    lcd_en_next    = lcd_en_reg;
    txn_done       = 1'b0;

    case (state_reg)
      PWRUP: begin
        if (cnt_reg == PWRUP_LAST) begin
          init_idx_next = 3'd0;
          lcd_rs_next   = 1'b0;
          lcd_data_next = init_cmd(3'd0);
          busy_next     = 1'b1;
          state_next    = SETUP;
        end
      end
      IDLE: begin
        if (ready0) begin
          lcd_rs_next   = req.req0_rs;
          lcd_data_next = req.req0_data;
          last_next     = 1'b0;
          busy_next     = 1'b1;
          state_next    = SETUP;
        end else if (ready1) begin
          lcd_rs_next   = req.req1_rs;
          lcd_data_next = req.req1_data;
          last_next     = 1'b1;
          busy_next     = 1'b1;
          state_next    = SETUP;
        end
      end
      SETUP: begin
        if (cnt_reg == SETUP_LAST) begin
          lcd_en_next = 1'b1;
          state_next  = STROBE;
        end
      end
      STROBE: begin
        if (cnt_reg == EN_LAST) begin
          lcd_en_next = 1'b0;
          if (is_slow_cmd) begin
            state_next = WAIT;
          end else begin
            txn_done = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == CLR_LAST) begin
          txn_done = 1'b1;
        end
      end
      default: begin
        // Unreachable encodings (INIT_CMD is resolved within the same
        // edge below) fall back to a clean power-up.
        lcd_en_next = 1'b0;
        busy_next   = 1'b0;
        state_next  = PWRUP;
      end
    endcase

    // The init step takes no cycle of its own: the next command is loaded
    // on the same edge the previous strobe (or clear wait) finishes, so the
    // whole sequence is exactly POWERUP + 5 transactions long.
    if (txn_done) begin
      if (ret_state == IDLE) begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end else if (init_idx_reg == INIT_LAST_IDX) begin
        init_done_next = 1'b1;
        busy_next      = 1'b0;
        state_next     = IDLE;
      end else begin
        init_idx_next = init_idx_reg + 3'd1;
        lcd_rs_next   = 1'b0;
        lcd_data_next = init_cmd(init_idx_reg + 3'd1);
        state_next    = SETUP;
      end
    end

    // Counter restarts on every state change and is parked in IDLE so it
    // never wraps while waiting for clients.
    if ((state_next != state_reg) || (state_reg == IDLE)) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= PWRUP;
      cnt_reg       <= '0;
      init_idx_reg  <= 3'd0;
      last_reg      <= 1'b1;
      init_done_reg <= 1'b0;
      busy_reg      <= 1'b0;
      lcd_rs_reg    <= 1'b0;
      lcd_data_reg  <= 8'h00;
      lcd_en_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      init_idx_reg  <= init_idx_next;
      last_reg      <= last_next;
      init_done_reg <= init_done_next;
      busy_reg      <= busy_next;
      lcd_rs_reg    <= lcd_rs_next;
      lcd_data_reg  <= lcd_data_next;
      lcd_en_reg    <= lcd_en_next;
    end
  end

  assign init_done = init_done_reg;
  assign busy      = busy_reg;
  assign lcd_rs    = lcd_rs_reg;
  assign lcd_rw    = 1'b0;
  assign lcd_en    = lcd_en_reg;
  assign lcd_data  = lcd_data_reg;

endmodule

// File: doc/lcd1602_bus_arbiter.md
Name: lcd1602_bus_arbiter

Overview:
- Owns the LCD1602 parallel bus: lcd_rs, lcd_rw, lcd_en and lcd_data.
- After reset it runs the power-up wait and the fixed init command sequence by itself.
- It then shares the bus between two client requesters, for example a text writer and a status/cursor updater, using round-robin arbitration.
- Each accepted request becomes exactly one timed bus write. Clear and home commands get an extra busy wait after the strobe.

Parameters:
- SETUP_CYC, 500: cycles lcd_en is low with rs/data stable before the strobe.
- EN_CYC, 500: cycles lcd_en is high.
- POWERUP_CYC, 7500: cycles of wait after reset before the first init command.
- CLR_WAIT_CYC, 80000: extra idle cycles after command 0x01 or 0x02 (rs=0).
- CNT_W, 20: width of the internal timing counter; must hold the largest parameter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req0_valid  in  1  requester 0 has a write pending.
- req0_rs  in  1  requester 0 register select (0 = command, 1 = data).
- req0_data  in  8  requester 0 byte.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req1_valid  in  1  requester 1 has a write pending.
- req1_rs  in  1  requester 1 register select.
- req1_data  in  8  requester 1 byte.
- req1_ready  out  1  requester 1 request accepted this cycle.
- init_done  out  1  init sequence complete; sticky until reset.
- busy  out  1  a bus transaction (init or client) is in progress.
- lcd_rs  out  1  LCD register select.
- lcd_rw  out  1  tied 0 (write only).
- lcd_en  out  1  LCD enable strobe.
- lcd_data  out  8  LCD data bus.

Behaviour:
- Reset: rst is sampled at posedge clk. While asserted:
  - lcd_rs=0, lcd_en=0, lcd_data=8'h00, init_done=0, busy=0;
  - both ready outputs 0;
  - round-robin pointer last=1, so requester 0 wins the first tie;
  - state=PWRUP, counter=0.
- Reset asserted mid-transaction aborts it immediately: lcd_en drops the next edge and no partial strobe is held.
- States: PWRUP, INIT_CMD, IDLE, SETUP, STROBE, WAIT.
- PWRUP: count POWERUP_CYC cycles, then load init index 0 and go to SETUP.
- Init sequence, all rs=0: 0x38, 0x08, 0x01, 0x06, 0x0C. INIT_CMD advances the index after each transaction. After the fifth command it sets init_done=1 and goes to IDLE.
- IDLE:
  - readyN is combinational: ready0 = valid0 & (~valid1 | last==1); ready1 = valid1 & (~valid0 | last==0).
  - ready is only ever asserted in IDLE with init_done=1. Never during PWRUP, init or any transaction, even if valid is held high.
  - On the accept edge: latch the winner's rs/data into lcd_rs/lcd_data, set last=winner, go to SETUP, and set busy=1 on the same edge.
  - Each request is accepted exactly once per ready pulse. A requester holding valid gets a new transaction each time it wins.
- SETUP: lcd_en=0 for SETUP_CYC cycles, then STROBE.
- STROBE: lcd_en=1 for EN_CYC cycles. On leaving, lcd_en=0.
  - If rs=0 and data is 0x01 or 0x02, go to WAIT for CLR_WAIT_CYC cycles.
  - Otherwise return to IDLE (or INIT_CMD during init).
- busy clears on the edge that returns to IDLE.
- Transaction length: SETUP_CYC+EN_CYC cycles, plus CLR_WAIT_CYC for clear/home. A new request can be accepted the cycle after busy falls, so back-to-back accepts are SETUP_CYC+EN_CYC+1 apart.
- Hold rule: lcd_rs/lcd_data change only on the accept edge (or init-load edge). They remain stable through SETUP, STROBE, WAIT and IDLE, so data is held across the falling edge of lcd_en.
- Counter: CNT_W bits, reset to 0 on every state change, compared against (param − 1). There is no wrap within a state.
- Round robin alternates strictly only under contention. A lone requester wins regardless of last, and winning updates last.

Test Plan:
- Params S=2, E=3, P=10, C=8; release rst. lcd_en must pulse exactly 5 times, with data 38, 08, 01, 06, 0C in that order. The third pulse is followed by 8 extra low cycles. init_done rises 10+5×5+8 = 43 cycles after reset release. No ready asserted before init_done.
- After init, req0 {rs=1, 0x41} for one cycle. Then: ready0=1 that cycle; lcd_rs=1 and lcd_data=0x41 next edge; lcd_en low 2 cycles, high 3 cycles; busy high 5 cycles.
- req0 and req1 both held valid with data 0x30 and 0x31. Accept order must be 0x30, 0x31, 0x30, 0x31. Accepts are 6 cycles apart and ready is never asserted for both at once.
- req1 {rs=0, 0x01} alone. lcd_en strobes once, then busy stays high 8 more cycles, then req0 is accepted on the first IDLE cycle.
- Assert rst during STROBE. The next edge must show lcd_en=0, lcd_data=0x00, init_done=0, state=PWRUP, and the full init sequence repeats.
- req0_valid held high through init. The first ready0 pulse occurs on the cycle init_done is 1 and state is IDLE, never earlier.
